// File: rtl/md_unit.sv
// md_unit: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO (optional MD_FAST_MUL_EN: single-cycle multiply)
module md_unit (
    input  logic        Clk,
    input  logic        RstN,
    input  logic        StartE,
    input  logic [1:0]  MdOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        HiLoWriteE,
    input  logic        HiLoE,
    output logic        BusyE,
    output logic [31:0] HiE,
    output logic [31:0] LoE
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, ma_q, ma_d, mb_q, mb_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        busy_q, busy_d;

    logic [31:0] in_ma, in_mb, rem_sub, quo, rem;
    logic [32:0] mul_sum, div_sh;
    logic        div_ge, neg;
    logic [63:0] prod, prod_s;

    // operand magnitudes are taken from the raw inputs so they can be latched on start
    assign in_ma   = (MdOpE[0] & SrcAE[31]) ? -SrcAE : SrcAE;
    assign in_mb   = (MdOpE[0] & SrcBE[31]) ? -SrcBE : SrcBE;
    // multiply: low half of acc holds the remaining multiplier bits, high half the running sum
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, ma_q} : 33'd0);
    // divide: acc = {remainder, dividend/quotient}; restored remainder always fits 32 bits
    assign div_sh  = {acc_q[63:32], acc_q[31]};
    assign div_ge  = div_sh >= {1'b0, mb_q};
    assign rem_sub = div_sh[31:0] - mb_q;
    assign neg     = op_q[0] & (a_q[31] ^ b_q[31]);
    assign quo     = acc_q[31:0];
    assign rem     = acc_q[63:32];
`ifdef MD_FAST_MUL_EN
    assign prod    = {32'b0, ma_q} * {32'b0, mb_q};
`else
    assign prod    = acc_q;
`endif
    assign prod_s  = neg ? -prod : prod;

    assign BusyE = busy_q;
    assign HiE   = hi_q;
    assign LoE   = lo_q;

    // state and datapath registers; reset discards any in-flight operation
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= IDLE;
            op_q    <= 2'b0;
            a_q     <= 32'b0;
            b_q     <= 32'b0;
            ma_q    <= 32'b0;
            mb_q    <= 32'b0;
            cnt_q   <= 6'b0;
            acc_q   <= 64'b0;
            hi_q    <= 32'b0;
            lo_q    <= 32'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    // next-state: accept start/MTHI/MTLO in IDLE, iterate in CALC, fix signs and commit in FIX
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (StartE) begin
                    op_d    = MdOpE;
                    a_d     = SrcAE;
                    b_d     = SrcBE;
                    ma_d    = in_ma;
                    mb_d    = in_mb;
                    cnt_d   = 6'd0;
                    acc_d   = MdOpE[1] ? {32'b0, in_ma} : {32'b0, in_mb};
                    state_d = CALC;
`ifdef MD_FAST_MUL_EN
                    if (!MdOpE[1]) state_d = FIX;
`endif
                end else if (HiLoWriteE) begin
                    hi_d = HiLoE ? SrcAE : hi_q;
                    lo_d = HiLoE ? lo_q : SrcAE;
                end
            end
            CALC: begin
                acc_d   = op_q[1] ? {(div_ge ? rem_sub : div_sh[31:0]), acc_q[30:0], div_ge}
                                  : {mul_sum, acc_q[31:1]};
                cnt_d   = cnt_q + 6'd1;
                state_d = (cnt_q == 6'd31) ? FIX : CALC;
            end
            FIX: begin
                if (op_q[1]) begin
                    hi_d = (b_q == 32'b0) ? a_q : ((op_q[0] & a_q[31]) ? -rem : rem);
                    lo_d = (b_q == 32'b0) ? 32'hFFFF_FFFF : (neg ? -quo : quo);
                end else begin
                    hi_d = prod_s[63:32];
                    lo_d = prod_s[31:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed scoreboard bench for md_unit
module tb_md_unit;
    logic        Clk = 1'b0;
    logic        RstN = 1'b0;
    logic        StartE = 1'b0;
    logic [1:0]  MdOpE = 2'b0;
    logic [31:0] SrcAE = 32'b0;
    logic [31:0] SrcBE = 32'b0;
    logic        HiLoWriteE = 1'b0;
    logic        HiLoE = 1'b0;
    logic        BusyE;
    logic [31:0] HiE, LoE;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb[$];
    logic [31:0] model_hi = 32'b0;
    logic [31:0] model_lo = 32'b0;

    md_unit dut (
        .Clk(Clk), .RstN(RstN), .StartE(StartE), .MdOpE(MdOpE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .HiLoWriteE(HiLoWriteE), .HiLoE(HiLoE),
        .BusyE(BusyE), .HiE(HiE), .LoE(LoE)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit with_write, input bit poke);
        int n;
        int exp_len;
        logic [63:0] got;
        exp_len = 33;
`ifdef MD_FAST_MUL_EN
        if (!op[1]) exp_len = 1;
`endif
        sb.push_back(exp);
        @(negedge Clk);
        StartE = 1'b1; MdOpE = op; SrcAE = a; SrcBE = b; HiLoWriteE = with_write; HiLoE = 1'b1;
        @(negedge Clk);
        StartE = 1'b0; HiLoWriteE = 1'b0; SrcAE = $urandom; SrcBE = $urandom;
        check({tag, "_hold_hi"}, HiE, model_hi);
        check({tag, "_hold_lo"}, LoE, model_lo);
        n = 0;
        while (BusyE === 1'b1 && n < 40) begin
            n++;
            StartE = poke && n == 5;
            HiLoWriteE = poke && n == 5;
            MdOpE = ~op;
            @(negedge Clk);
        end
        StartE = 1'b0; HiLoWriteE = 1'b0;
        check({tag, "_busy_len"}, n, exp_len);
        got = sb.pop_front();
        model_hi = got[63:32];
        model_lo = got[31:0];
        check({tag, "_hi"}, HiE, model_hi);
        check({tag, "_lo"}, LoE, model_lo);
        check({tag, "_idle"}, BusyE, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_busy", BusyE, 1'b0);
        check("rst_hi", HiE, 32'h0);
        check("rst_lo", LoE, 32'h0);
        RstN = 1'b1;
        @(negedge Clk);
        check("post_rst_hi", HiE, 32'h0);
        check("post_rst_lo", LoE, 32'h0);

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0);
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0);
        run_op("mult_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 1'b0);
        run_op("divu", 2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b0);
        run_op("div_negb", 2'b11, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0, 1'b0);
        run_op("divu_zero", 2'b10, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 1'b0, 1'b0);
        run_op("div_zero", 2'b11, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b0, 1'b0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0, 1'b0);

        @(negedge Clk);
        HiLoWriteE = 1'b1; HiLoE = 1'b1; SrcAE = 32'hA5A5_A5A5;
        @(negedge Clk);
        model_hi = 32'hA5A5_A5A5;
        check("mthi_hi", HiE, model_hi);
        check("mthi_lo", LoE, model_lo);
        HiLoE = 1'b0; SrcAE = 32'h5A5A_5A5A;
        @(negedge Clk);
        HiLoWriteE = 1'b0;
        model_lo = 32'h5A5A_5A5A;
        check("mtlo_lo", LoE, model_lo);
        check("mtlo_hi", HiE, model_hi);

        run_op("start_wr", 2'b10, 32'd1000, 32'd10, {32'd0, 32'd100}, 1'b1, 1'b0);
        run_op("poke", 2'b11, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0, 1'b1);

        @(negedge Clk);
        StartE = 1'b1; MdOpE = 2'b10; SrcAE = 32'd1000; SrcBE = 32'd3;
        @(negedge Clk);
        StartE = 1'b0;
        repeat (9) @(negedge Clk);
        check("pre_rst_busy", BusyE, 1'b1);
        RstN = 1'b0;
        #1;
        model_hi = 32'h0;
        model_lo = 32'h0;
        check("midrst_busy", BusyE, 1'b0);
        check("midrst_hi", HiE, model_hi);
        check("midrst_lo", LoE, model_lo);
        @(negedge Clk);
        RstN = 1'b1;
        run_op("multu_small", 2'b00, 32'd3, 32'd5, {32'd0, 32'd15}, 1'b0, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
